// File: rtl/axis_icrc_insert_if.sv
// axis_icrc_insert_if: AXI-Stream frame bundle used on both sides of axis_icrc_insert
interface axis_icrc_insert_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_icrc_insert.sv
// axis_icrc_insert: appends the 32-bit ICRC as the last 4 frame bytes; define ICRC_TUSER_POISON_EN to invert the ICRC of frames whose last beat has tuser[0]=1
module axis_icrc_insert #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  axis_icrc_insert_if.slave  s_axis,
  input  logic [31:0]        s_icrc_tdata,
  input  logic               s_icrc_tvalid,
  output logic               s_icrc_tready,
  axis_icrc_insert_if.master m_axis
);
  localparam int W = DATA_WIDTH / 8;
  localparam int NW = $clog2(W + 1);
  typedef enum logic [1:0] {PASS, WAIT_CRC, SPILL} state_t;
  state_t r_state;
  logic [DATA_WIDTH-1:0] r_l_data, r_m_data, r_t_data, w_p_data, w_mrg_data;
  logic [W-1:0] r_m_keep, r_t_keep, r_sp_keep, w_p_keep, w_mrg_keep, w_sp_keep;
  logic [USER_WIDTH-1:0] r_l_user, r_m_user, r_t_user, w_p_user;
  logic [NW-1:0] r_n, w_n;
  logic [31:0] r_sp, w_icrc;
  logic r_m_valid, r_m_last, r_t_valid, r_t_last, r_in_ready;
  logic w_push, w_p_last, w_fits, w_s_fire, w_c_fire;

`ifdef ICRC_TUSER_POISON_EN
  assign w_icrc = r_l_user[0] ? ~s_icrc_tdata : s_icrc_tdata;
`else
  assign w_icrc = s_icrc_tdata;
`endif

  assign s_axis.tready = r_state == PASS && r_in_ready;
  assign s_icrc_tready = r_state == WAIT_CRC && r_in_ready;
  assign w_s_fire = s_axis.tvalid && s_axis.tready;
  assign w_c_fire = s_icrc_tvalid && s_icrc_tready;
  assign w_fits = int'(r_n) <= W - 4;

  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata = r_m_data;
  assign m_axis.tkeep = r_m_keep;
  assign m_axis.tlast = r_m_last;
  assign m_axis.tuser = r_m_user;

  // byte count of the incoming beat; becomes the ICRC insertion offset when tlast is accepted
  always_comb begin
    w_n = '0;
    for (int i = 0; i < W; i++) w_n = w_n + NW'(s_axis.tkeep[i]);
  end

  // last beat with the ICRC overlaid at byte n, plus the keep mask for any overflow beat
  always_comb begin
    w_mrg_data = '0;
    w_mrg_keep = '0;
    w_sp_keep = '0;
    for (int i = 0; i < W; i++) begin
      w_mrg_data[8*i +: 8] = i < int'(r_n) ? r_l_data[8*i +: 8] :
                             i < int'(r_n) + 4 ? w_icrc[8*((i - int'(r_n)) & 3) +: 8] : 8'h00;
      w_mrg_keep[i] = i < int'(r_n) + 4;
      w_sp_keep[i] = i < int'(r_n) + 4 - W;
    end
  end

  // selects what the sequencer loads into the output stage this cycle
  always_comb begin
    w_push = r_state == PASS ? w_s_fire && !s_axis.tlast : r_state == WAIT_CRC ? w_c_fire : r_in_ready;
    w_p_data = r_state == PASS ? s_axis.tdata : r_state == WAIT_CRC ? w_mrg_data : DATA_WIDTH'(r_sp);
    w_p_keep = r_state == PASS ? s_axis.tkeep : r_state == WAIT_CRC ? w_mrg_keep : r_sp_keep;
    w_p_last = r_state == PASS ? 1'b0 : r_state == WAIT_CRC ? w_fits : 1'b1;
    w_p_user = r_state == PASS ? s_axis.tuser : r_l_user;
  end

  // frame sequencing: pass beats, hold the last one until its ICRC arrives, then spill any overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PASS;
      r_l_data <= '0;
      r_l_user <= '0;
      r_n <= '0;
      r_sp <= '0;
      r_sp_keep <= '0;
    end else if (r_state == PASS && w_s_fire && s_axis.tlast) begin
      r_state <= WAIT_CRC;
      r_l_data <= s_axis.tdata;
      r_l_user <= s_axis.tuser;
      r_n <= w_n;
    end else if (r_state == WAIT_CRC && w_c_fire) begin
      r_state <= w_fits ? PASS : SPILL;
      r_sp <= w_icrc >> (8 * (W - int'(r_n)));
      r_sp_keep <= w_sp_keep;
    end else if (r_state == SPILL && r_in_ready) begin
      r_state <= PASS;
      r_sp <= '0;
    end
  end

  // two-entry output skid: r_in_ready depends only on registers, so m_axis.tready never reaches upstream combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data <= '0;
      r_m_keep <= '0;
      r_m_last <= 1'b0;
      r_m_user <= '0;
      r_t_valid <= 1'b0;
      r_t_data <= '0;
      r_t_keep <= '0;
      r_t_last <= 1'b0;
      r_t_user <= '0;
    end else begin
      r_in_ready <= m_axis.tready || (!r_t_valid && (!r_m_valid || !w_push));
      if (r_in_ready && (m_axis.tready || !r_m_valid)) begin
        r_m_valid <= w_push;
        r_m_data <= w_p_data;
        r_m_keep <= w_p_keep;
        r_m_last <= w_p_last;
        r_m_user <= w_p_user;
      end else if (r_in_ready) begin
        r_t_valid <= w_push;
        r_t_data <= w_p_data;
        r_t_keep <= w_p_keep;
        r_t_last <= w_p_last;
        r_t_user <= w_p_user;
      end else if (m_axis.tready) begin
        r_m_valid <= r_t_valid;
        r_m_data <= r_t_data;
        r_m_keep <= r_t_keep;
        r_m_last <= r_t_last;
        r_m_user <= r_t_user;
        r_t_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_icrc_insert.sv
// tb_axis_icrc_insert: scoreboard bench for axis_icrc_insert at DATA_WIDTH=64
module tb_axis_icrc_insert;
  localparam int W = 8;
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic clk = 0;
  logic rst = 1;
  logic [31:0] s_icrc_tdata;
  logic s_icrc_tvalid;
  logic s_icrc_tready;
  axis_icrc_insert_if #(.DATA_WIDTH(64), .USER_WIDTH(1)) s_axis ();
  axis_icrc_insert_if #(.DATA_WIDTH(64), .USER_WIDTH(1)) m_axis ();

  axis_icrc_insert #(.DATA_WIDTH(64), .USER_WIDTH(1)) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_axis),
    .s_icrc_tdata(s_icrc_tdata),
    .s_icrc_tvalid(s_icrc_tvalid),
    .s_icrc_tready(s_icrc_tready),
    .m_axis(m_axis)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  int lasts = 0;
  int icrcs = 0;
  beat_t exp_q[$];
  logic [31:0] icrc_q[$];
  beat_t e;
  logic prev_stall = 0;
  logic [63:0] prev_d;
  logic [9:0] prev_k;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] r = '0;
    for (int i = 0; i < W; i++) if (k[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int t = 0;
    s_axis.tdata = d;
    s_axis.tkeep = k;
    s_axis.tlast = l;
    s_axis.tuser = u;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis.tready && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 2000) check("s_tmo", 64'(s_axis.tready), 1);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [31:0] icrc, input bit zlast, input bit push_icrc, input int umode);
    logic [7:0] b[$];
    logic uin[$];
    logic [31:0] c;
    beat_t x;
    int nin, nout, idx;
    logic [63:0] d;
    logic [7:0] k;
    nin = (len + W - 1) / W + (zlast ? 1 : 0);
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    for (int j = 0; j < nin; j++) uin.push_back(umode == 2 ? 1'($urandom_range(0, 1)) : 1'(umode == 1));
    c = icrc;
`ifdef ICRC_TUSER_POISON_EN
    if (uin[nin-1]) c = ~icrc;
`endif
    nout = (len + 4 + W - 1) / W;
    for (int j = 0; j < nout; j++) begin
      x.d = '0;
      x.k = '0;
      for (int i = 0; i < W; i++) begin
        idx = j * W + i;
        if (idx < len) begin
          x.d[8*i +: 8] = b[idx];
          x.k[i] = 1'b1;
        end else if (idx < len + 4) begin
          x.d[8*i +: 8] = c[8*(idx-len) +: 8];
          x.k[i] = 1'b1;
        end
      end
      x.l = j == nout - 1;
      x.u = uin[j < nin ? j : nin - 1];
      exp_q.push_back(x);
    end
    if (push_icrc) icrc_q.push_back(icrc);
    for (int j = 0; j < nin; j++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < W; i++) begin
        idx = j * W + i;
        if (idx < len) begin
          d[8*i +: 8] = b[idx];
          k[i] = 1'b1;
        end
      end
      send_beat(d, k, j == nin - 1, uin[j]);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // downstream ready: 0 always-on, 1 random 50%, 2 stalled
  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis.tready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'(rdy_mode == 0);
    end
  end

  // ICRC source: presents queued values in order as soon as they are queued
  initial begin
    s_icrc_tvalid = 1'b0;
    s_icrc_tdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (icrc_q.size() != 0) begin
        s_icrc_tdata = icrc_q[0];
        s_icrc_tvalid = 1'b1;
        @(negedge clk);
        while (!s_icrc_tready) @(negedge clk);
        @(posedge clk);
        #1;
        void'(icrc_q.pop_front());
        s_icrc_tvalid = 1'b0;
      end
    end
  end

  // output monitor: scoreboard compare, stall stability, ICRC-not-early
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      lasts = 0;
      icrcs = 0;
    end else begin
      if (prev_stall) begin
        check("hold_v", 64'(m_axis.tvalid), 1);
        check("hold_d", m_axis.tdata, prev_d);
        check("hold_k", {m_axis.tuser, m_axis.tlast, m_axis.tkeep}, 64'(prev_k));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) check("extra_beat", 64'(m_axis.tvalid), 0);
        else begin
          e = exp_q.pop_front();
          check("data", mask(m_axis.tdata, e.k), e.d);
          check("keep", 64'(m_axis.tkeep), 64'(e.k));
          check("last", 64'(m_axis.tlast), 64'(e.l));
          check("user", 64'(m_axis.tuser), 64'(e.u));
        end
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_d = m_axis.tdata;
      prev_k = {m_axis.tuser, m_axis.tlast, m_axis.tkeep};
      if (s_icrc_tvalid && s_icrc_tready) begin
        check("icrc_early", 64'(lasts > icrcs), 1);
        icrcs++;
      end
      if (s_axis.tvalid && s_axis.tready && s_axis.tlast) lasts++;
    end
  end

  initial begin
    logic [31:0] ic;
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    s_axis.tkeep = '0;
    s_axis.tlast = 1'b0;
    s_axis.tuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mvalid", 64'(m_axis.tvalid), 0);
    check("rst_mlast", 64'(m_axis.tlast), 0);
    check("rst_mdata", m_axis.tdata, 0);
    check("rst_mkeep", 64'(m_axis.tkeep), 0);
    check("rst_sready", 64'(s_axis.tready), 0);
    check("rst_cready", 64'(s_icrc_tready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(20, 32'hDDCCBBAA, 0, 1, 0);
    drain();
    send_frame(16, 32'h44332211, 0, 1, 0);
    drain();
    send_frame(14, 32'h44332211, 0, 1, 0);
    drain();
    send_frame(8, 32'h87654321, 1, 1, 0);
    drain();
    send_frame(12, 32'h00000000, 0, 1, 1);
    drain();
    ic = 32'h5A5AA5A5;
    send_frame(10, ic, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dly_sready", 64'(s_axis.tready), 0);
      check("dly_tlast", 64'(m_axis.tvalid && m_axis.tlast), 0);
    end
    icrc_q.push_back(ic);
    drain();
    icrc_q.push_back(32'h11111111);
    icrc_q.push_back(32'h22222222);
    icrc_q.push_back(32'h33333333);
    send_frame(7, 32'h11111111, 0, 0, 2);
    send_frame(13, 32'h22222222, 0, 0, 2);
    send_frame(24, 32'h33333333, 0, 0, 2);
    drain();
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_beat(64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_mvalid", 64'(m_axis.tvalid), 0);
    check("mid_rst_sready", 64'(s_axis.tready), 0);
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 0;
    send_frame(11, 32'hCAFEF00D, 0, 1, 0);
    drain();
    rdy_mode = 1;
    for (int f = 0; f < 100; f++) send_frame($urandom_range(1, 40), $urandom, 0, 1, 2);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
